// File: rtl/rgb_pixel_pipeline.sv
// VGA pixel output stage: mode latch, test-pattern select, blanking and a
// LATENCY-deep pipeline that carries colour and sync together to the pins.
module rgb_pixel_pipeline #(
  parameter int   CH_W       = 4,
  parameter int   LATENCY    = 2,
  parameter int   H_ACTIVE   = 640,
  parameter int   V_ACTIVE   = 480,
  parameter int   CHECK_LOG2 = 4,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [10:0]       row,
  input  logic [10:0]       column,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [3*CH_W-1:0] colour_data,
  input  logic [1:0]        mode,
  input  logic [3*CH_W-1:0] solid_colour,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [1:0]        mode_active
);

  localparam int PW    = 3 * CH_W;
  localparam int BAR_W = H_ACTIVE / 8;

  logic [1:0]    mode_active_d, mode_active_q;
  logic [PW-1:0] pix_d [LATENCY];
  logic [PW-1:0] pix_q [LATENCY];
  logic [LATENCY-1:0] hs_d, hs_q, vs_d, vs_q;
  logic [2:0]    bar_k_s;
  logic [PW-1:0] sel_s;

  // Mode latch, bar index, pattern select and blanking for the incoming pixel.
  always_comb begin
    mode_active_d = mode_active_q;
    if ((row == 11'(V_ACTIVE)) && (column == 11'd0)) begin
      mode_active_d = mode;
    end else begin
      mode_active_d = mode_active_q;
    end

    // Counting thresholds passed gives the bar index and clamps wide columns to 7.
    bar_k_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      bar_k_s = bar_k_s + {2'b00, ({1'b0, column} >= 12'(i * BAR_W))};
    end

    case (mode_active_q)
      2'd0:    sel_s = colour_data;
      2'd1:    sel_s = {{CH_W{bar_k_s[2]}}, {CH_W{bar_k_s[1]}}, {CH_W{bar_k_s[0]}}};
      2'd2:    sel_s = {PW{row[CHECK_LOG2] ^ column[CHECK_LOG2]}};
      2'd3:    sel_s = solid_colour;
      default: sel_s = '0;
    endcase

    pix_d[0] = en ? sel_s : '0;
    hs_d[0]  = hsync_in;
    vs_d[0]  = vsync_in;
    for (int i = 1; i < LATENCY; i++) begin
      pix_d[i] = pix_q[i-1];
      hs_d[i]  = hs_q[i-1];
      vs_d[i]  = vs_q[i-1];
    end
  end

  // Pipeline and mode registers; syncs idle at SYNC_IDLE so reset never emits a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_active_q <= 2'd0;
      hs_q          <= {LATENCY{SYNC_IDLE}};
      vs_q          <= {LATENCY{SYNC_IDLE}};
      for (int i = 0; i < LATENCY; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      mode_active_q <= mode_active_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      for (int i = 0; i < LATENCY; i++) begin
        pix_q[i] <= pix_d[i];
      end
    end
  end

  assign r           = pix_q[LATENCY-1][PW-1 -: CH_W];
  assign g           = pix_q[LATENCY-1][2*CH_W-1 -: CH_W];
  assign b           = pix_q[LATENCY-1][CH_W-1:0];
  assign hsync_out   = hs_q[LATENCY-1];
  assign vsync_out   = vs_q[LATENCY-1];
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_rgb_pixel_pipeline.sv
// Directed bench for rgb_pixel_pipeline with default parameters (LATENCY = 2).
module tb_rgb_pixel_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [10:0] row = 11'd0;
  logic [10:0] column = 11'd0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [11:0] colour_data = 12'h000;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_colour = 12'h000;
  logic [3:0]  r, g, b;
  logic        hsync_out, vsync_out;
  logic [1:0]  mode_active;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] prev_exp = 12'h000;
  logic        prev_hs = 1'b1;
  int          low_cnt;
  logic [11:0] bar_tab [8];

  rgb_pixel_pipeline dut (
    .clk(clk), .rst(rst), .en(en), .row(row), .column(column),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .colour_data(colour_data),
    .mode(mode), .solid_colour(solid_colour), .r(r), .g(g), .b(b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, clock it in, and check the pixel driven on the previous call.
  task automatic pump(input string tag, input logic [10:0] rw, input logic [10:0] cl,
                      input logic [11:0] cd, input logic [11:0] exp);
    row = rw;
    column = cl;
    colour_data = cd;
    @(posedge clk);
    #1;
    check_eq(tag, {20'd0, r, g, b}, {20'd0, prev_exp});
    prev_exp = exp;
  endtask

  initial begin
    bar_tab[0] = 12'h000; bar_tab[1] = 12'h00F; bar_tab[2] = 12'h0F0; bar_tab[3] = 12'h0FF;
    bar_tab[4] = 12'hF00; bar_tab[5] = 12'hF0F; bar_tab[6] = 12'hFF0; bar_tab[7] = 12'hFFF;

    // Reset state
    #12;
    check_eq("rst_rgb", {20'd0, r, g, b}, 32'h0);
    check_eq("rst_hs", {31'd0, hsync_out}, 32'd1);
    check_eq("rst_vs", {31'd0, vsync_out}, 32'd1);
    check_eq("rst_mode", {30'd0, mode_active}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-line asynchronous reset
    en = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    pump("pre_fill", 11'd10, 11'd1, 12'hFFF, 12'hFFF);
    pump("pre_fill", 11'd10, 11'd2, 12'hFFF, 12'hFFF);
    check_eq("pre_hs", {31'd0, hsync_out}, 32'd0);
    check_eq("pre_vs", {31'd0, vsync_out}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rgb", {20'd0, r, g, b}, 32'h0);
    check_eq("async_hs", {31'd0, hsync_out}, 32'd1);
    check_eq("async_vs", {31'd0, vsync_out}, 32'd1);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_exp = 12'h000;

    // Pass-through with exact two-clock latency
    pump("pass_a", 11'd20, 11'd0, 12'h000, 12'h000);
    pump("pass_b", 11'd20, 11'd1, 12'h123, 12'h123);
    check_eq("lat_not_yet", {20'd0, r, g, b}, 32'h0);
    pump("pass_c", 11'd20, 11'd2, 12'h456, 12'h456);
    pump("pass_d", 11'd20, 11'd3, 12'h000, 12'h000);

    // Blanking with a 96-clock hsync pulse
    en = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 101; i++) begin
      hsync_in = (i >= 2 && i < 98) ? 1'b0 : 1'b1;
      pump("blank_rgb", 11'd30, 11'(i), 12'hFFF, 12'h000);
      check_eq("blank_hs", {31'd0, hsync_out}, {31'd0, prev_hs});
      if (hsync_out == 1'b0) low_cnt++;
      prev_hs = hsync_in;
    end
    check_eq("hs_low_cnt", low_cnt, 96);
    check_eq("blank_vs", {31'd0, vsync_out}, 32'd1);
    hsync_in = 1'b1;
    en = 1'b1;

    // Colour bars, including columns past the last full bar
    mode = 2'd1;
    pump("bar_latch", 11'd480, 11'd0, 12'h7E1, 12'h7E1);
    check_eq("mode_bar", {30'd0, mode_active}, 32'd1);
    for (int c = 0; c < 640; c++) begin
      pump("bar", 11'd0, 11'(c), 12'h5A5, bar_tab[(c / 80 > 7) ? 7 : c / 80]);
    end
    pump("bar_640", 11'd0, 11'd640, 12'h5A5, 12'hFFF);
    pump("bar_2047", 11'd0, 11'd2047, 12'h5A5, 12'hFFF);

    // Checkerboard
    mode = 2'd2;
    pump("chk_latch", 11'd480, 11'd0, 12'h5A5, 12'h000);
    check_eq("mode_chk", {30'd0, mode_active}, 32'd2);
    pump("chk_0_0", 11'd0, 11'd0, 12'h5A5, 12'h000);
    pump("chk_0_16", 11'd0, 11'd16, 12'h5A5, 12'hFFF);
    pump("chk_16_16", 11'd16, 11'd16, 12'h5A5, 12'h000);
    pump("chk_16_0", 11'd16, 11'd0, 12'h5A5, 12'hFFF);
    pump("chk_15_15", 11'd15, 11'd15, 12'h5A5, 12'h000);

    // Mode request mid-frame only takes effect after the latch point
    mode = 2'd0;
    pump("m0_latch", 11'd480, 11'd0, 12'h5A5, 12'h000);
    mode = 2'd3;
    solid_colour = 12'h3C9;
    pump("m3_wait_a", 11'd100, 11'd5, 12'h5A5, 12'h5A5);
    pump("m3_wait_b", 11'd100, 11'd6, 12'h123, 12'h123);
    check_eq("mode_hold", {30'd0, mode_active}, 32'd0);
    pump("m3_latch_px", 11'd480, 11'd0, 12'hABC, 12'hABC);
    check_eq("mode_solid", {30'd0, mode_active}, 32'd3);
    pump("m3_first", 11'd480, 11'd1, 12'hDEF, 12'h3C9);
    pump("m3_second", 11'd481, 11'd2, 12'h000, 12'h3C9);
    en = 1'b0;
    pump("m3_blank", 11'd481, 11'd3, 12'h000, 12'h000);
    en = 1'b1;
    pump("flush_a", 11'd481, 11'd4, 12'h000, 12'h3C9);
    pump("flush_b", 11'd481, 11'd5, 12'h000, 12'h3C9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
